// File: rtl/spi_master_if.sv
// spi_master_if
//   Groups the frame-request handshake and the SPI link pins of spi_master.
//   Clock and reset are plain ports of the block, so they are not carried here.
//
//   Signals:
//     start    request a frame (host -> master)
//     cmd      2-bit frame command (host -> master)
//     data_in  payload byte (host -> master)
//     busy     frame in progress (master -> host)
//     done     one-cycle end-of-frame pulse (master -> host)
//     rx_data  byte captured by the last read-data frame (master -> host)
//     SS_n     slave select, active low (master -> slave)
//     MOSI     serial data, MSB first (master -> slave)
//     MISO     serial data, MSB first (slave -> master)
//
//   Modports:
//     master   the spi_master block's view
//     slave    the view of whatever sits around it (host plus SPI slave)
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, data_in, MISO,
    output busy, done, rx_data, SS_n, MOSI
  );

  modport slave (
    output start, cmd, data_in, MISO,
    input  busy, done, rx_data, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// spi_master
//   Single-clock SPI master. A frame is a 2-bit command followed by a data
//   byte, shifted out MSB first on MOSI. Read-data frames (cmd 11) then wait
//   READ_GAP cycles and shift in one byte from MISO, MSB first.
//   Every output is driven straight from a flop.
//
//   Parameters:
//     READ_GAP  cycles between the last MOSI bit and the first MISO sample (1..7)
//
//   Ports:
//     clk   rising-edge clock for the block and the SPI link
//     rst   asynchronous active-high reset
//     bus   spi_master_if.master (start/cmd/data_in/busy/done/rx_data/SS_n/MOSI/MISO)
module spi_master #(
  parameter int READ_GAP = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    GAP    = 3'd3,
    RECV   = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [3:0] FRAME_BITS  = 4'd10;
  localparam logic [3:0] RX_BITS     = 4'd8;
  // The first MISO sample is taken on the edge that ends the gap, so the gap
  // counter stops one short of READ_GAP.
  localparam logic [3:0] GAP_LAST    = 4'(READ_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] frame_q, frame_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rd_frame_q, rd_frame_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rx_data_q, rx_data_d;

  // State, counter, shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= 10'd0;
      rx_shift_q <= 8'd0;
      rd_frame_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      rx_shift_q <= rx_shift_d;
      rd_frame_q <= rd_frame_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next-state logic; output values are computed for the state being entered
  // so that the flops present them right after the transition edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    rx_shift_d = rx_shift_q;
    rd_frame_d = rd_frame_q;
    ss_n_d     = 1'b0;
    mosi_d     = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Command and payload are captured here; later input changes are ignored.
          state_d    = START;
          frame_d    = {bus.cmd, bus.data_in};
          rd_frame_d = (bus.cmd == CMD_RD_DATA);
          cnt_d      = 4'd0;
          rx_shift_d = 8'd0;
        end else begin
          state_d = IDLE;
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      START: begin
        state_d = SHIFT;
        mosi_d  = frame_q[9];
        frame_d = {frame_q[8:0], 1'b0};
        cnt_d   = 4'd1;
      end

      SHIFT: begin
        if (cnt_q == FRAME_BITS) begin
          cnt_d = 4'd0;
          if (rd_frame_q) begin
            state_d = GAP;
          end else begin
            state_d = FINISH;
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          mosi_d  = frame_q[9];
          frame_d = {frame_q[8:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d    = RECV;
          rx_shift_d = {rx_shift_q[6:0], bus.MISO};
          cnt_d      = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      RECV: begin
        if (cnt_q == RX_BITS) begin
          state_d   = FINISH;
          rx_data_d = rx_shift_q;
          ss_n_d    = 1'b1;
          done_d    = 1'b1;
          cnt_d     = 4'd0;
        end else begin
          rx_shift_d = {rx_shift_q[6:0], bus.MISO};
          cnt_d      = cnt_q + 4'd1;
        end
      end

      FINISH: begin
        // start is not looked at here, so a request during FINISH is dropped.
        state_d = IDLE;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.SS_n    = ss_n_q;
  assign bus.MOSI    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if bus();
  spi_master_if bus1();

  spi_master #(.READ_GAP(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_master #(.READ_GAP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] rx;
    int         e0;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  // Edge counter: after edge Ek has been applied, cyc equals the k-th count.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM-backed SPI slave on the READ_GAP=2 instance.
  localparam int RG = 2;
  int         s_cnt   = 0;
  logic [9:0] s_frame = 10'd0;
  logic [7:0] s_addr  = 8'h00;
  logic [7:0] s_out   = 8'h00;
  logic [7:0] s_mem [256];

  always @(posedge clk) begin
    if (bus.SS_n !== 1'b0) begin
      s_cnt = 0;
      bus.MISO <= 1'b1;
    end else begin
      s_cnt = s_cnt + 1;
      if (s_cnt >= 2 && s_cnt <= 11) s_frame = {s_frame[8:0], bus.MOSI};
      if (s_cnt == 11) begin
        case (s_frame[9:8])
          2'b00:   s_addr = s_frame[7:0];
          2'b01:   s_mem[s_addr] = s_frame[7:0];
          2'b10:   s_addr = s_frame[7:0];
          default: s_out = s_mem[s_addr];
        endcase
      end
      if (s_cnt >= 10 + RG && s_cnt < 18 + RG) bus.MISO <= s_out[17 + RG - s_cnt];
      else                                     bus.MISO <= 1'b1;
    end
  end

  // Scripted slave on the READ_GAP=1 instance: returns 8'h5C, drives 1 elsewhere.
  int         s1_cnt = 0;
  logic [7:0] s1_pat = 8'h5C;

  always @(posedge clk) begin
    if (bus1.SS_n !== 1'b0) begin
      s1_cnt = 0;
      bus1.MISO <= 1'b1;
    end else begin
      s1_cnt = s1_cnt + 1;
      if (s1_cnt >= 11 && s1_cnt <= 18) bus1.MISO <= s1_pat[18 - s1_cnt];
      else                              bus1.MISO <= 1'b1;
    end
  end

  // Scoreboard monitor: every done pulse pops one expected frame result.
  always @(negedge clk) begin
    exp_t it;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        it = sb_q.pop_front();
        chk("rx_data_at_done", 32'(bus.rx_data), 32'(it.rx));
        chk("done_latency", 32'(cyc - it.e0), 32'(it.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [7:0] d,
                       input logic [7:0] exp_rx, input bit expect_done);
    exp_t it;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cmd     = c;
    bus.data_in = d;
    it.rx  = exp_rx;
    it.e0  = cyc + 1;
    it.lat = (c == 2'b11) ? 21 : 11;
    if (expect_done) sb_q.push_back(it);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.cmd     = ~c;
    bus.data_in = ~d;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t       it;
    logic [9:0] mosi_trace;
    logic       ss_ok;

    rst = 1'b0;
    bus.start  = 1'b0; bus.cmd  = 2'b00; bus.data_in  = 8'h00;
    bus1.start = 1'b0; bus1.cmd = 2'b00; bus1.data_in = 8'h00;
    #1 rst = 1'b1;
    #2;
    chk("rst_ss_n", 32'(bus.SS_n), 32'd1);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write-address A5: MOSI trace, start pulses at E5 and in FINISH ignored.
    issue(2'b00, 8'hA5, 8'h00, 1'b1);
    chk("ss_n_after_e0", 32'(bus.SS_n), 32'd0);
    chk("busy_after_e0", 32'(bus.busy), 32'd1);
    mosi_trace = 10'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      mosi_trace = {mosi_trace[8:0], bus.MOSI};
      bus.start = (i == 4);
    end
    chk("mosi_seq_a5", 32'(mosi_trace), 32'(10'b0010100101));
    @(negedge clk);
    chk("finish_ss_n", 32'(bus.SS_n), 32'd1);
    chk("finish_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_after_finish", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("finish_start_not_queued", 32'(bus.busy), 32'd0);

    // Round trip through the RAM slave.
    issue(2'b00, 8'h12, 8'h00, 1'b1); wait_idle("idle_wa12");
    issue(2'b01, 8'h3C, 8'h00, 1'b1); wait_idle("idle_wd3c");
    issue(2'b10, 8'h12, 8'h00, 1'b1); wait_idle("idle_ra12");
    issue(2'b11, 8'h00, 8'h3C, 1'b1); wait_idle("idle_rd_3c");

    // Read-data returning B2 with SS_n held low E0..E20.
    issue(2'b00, 8'h40, 8'h3C, 1'b1); wait_idle("idle_wa40");
    issue(2'b01, 8'hB2, 8'h3C, 1'b1); wait_idle("idle_wdb2");
    issue(2'b10, 8'h40, 8'h3C, 1'b1); wait_idle("idle_ra40");
    issue(2'b11, 8'hFF, 8'hB2, 1'b1);
    ss_ok = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.SS_n !== 1'b0) ss_ok = 1'b0;
    end
    chk("ss_n_low_e0_e20", 32'(ss_ok), 32'd1);
    wait_idle("idle_rd_b2");

    // Back-to-back: start held high, second frame accepted at E13.
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b01; bus.data_in = 8'h77;
    it.rx = 8'hB2; it.e0 = cyc + 1; it.lat = 11;
    sb_q.push_back(it);
    it.e0 = it.e0 + 13;
    sb_q.push_back(it);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 12) chk("ss_n_high_between", 32'(bus.SS_n), 32'd1);
    end
    bus.start = 1'b0;
    chk("b2b_second_busy", 32'(bus.busy), 32'd1);
    wait_idle("idle_b2b");

    // Reset during RECV after four samples.
    issue(2'b11, 8'h00, 8'h00, 1'b0);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ss_n", 32'(bus.SS_n), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rx_data", 32'(bus.rx_data), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_stays_idle", 32'(bus.busy), 32'd0);
    issue(2'b11, 8'h00, 8'h77, 1'b1); wait_idle("idle_rd_77");

    // READ_GAP=1 instance: samples E12..E19, done after E20.
    @(negedge clk);
    bus1.start = 1'b1; bus1.cmd = 2'b11; bus1.data_in = 8'h00;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("rg1_done_not_early", 32'(bus1.done), 32'd0);
    @(negedge clk);
    chk("rg1_done_e20", 32'(bus1.done), 32'd1);
    chk("rg1_rx_data", 32'(bus1.rx_data), 32'h5C);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
